// File: rtl/univ_shift_engine.sv
// univ_shift_engine
//   Universal shift/rotate register with a multi-bit amount per cycle,
//   registered serial outputs at both ends and a burst engine that repeats
//   one latched operation a programmed number of cycles.
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   en                    single-step op with live inputs (IDLE only)
//   start, count          launch a burst of count ops (IDLE only, beats en)
//   op, shamt             operation select and shift/rotate amount
//   sin_l, sin_r          fill bits for SHR (MSB side) / SHL (LSB side)
//   d                     parallel load data
//   q                     register contents
//   sout_l, sout_r        last bit pushed out of the MSB / LSB side
//   busy, done            burst in progress / one-cycle burst-complete pulse
module univ_shift_engine #(
  parameter int N  = 8,
  parameter int SW = $clog2(N),
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [SW-1:0] shamt,
  input  logic          sin_l,
  input  logic          sin_r,
  input  logic [N-1:0]  d,
  input  logic [CW-1:0] count,
  output logic [N-1:0]  q,
  output logic          sout_l,
  output logic          sout_r,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000, OP_LOAD = 3'b001, OP_SHL = 3'b010, OP_SHR = 3'b011,
    OP_ROL  = 3'b100, OP_ROR  = 3'b101, OP_ASR = 3'b110, OP_CLR = 3'b111
  } op_e;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e        state;
  logic [2:0]    op_r;
  logic [SW-1:0] shamt_r;
  logic          sin_l_r, sin_r_r;
  logic [N-1:0]  d_r;
  logic [CW-1:0] rem;

  // operand select: latched copy during a burst, live inputs otherwise
  logic          run, exec;
  logic [2:0]    x_op;
  logic [SW-1:0] x_sh;
  logic          x_sinl, x_sinr;
  logic [N-1:0]  x_d;

  assign run    = (state == S_RUN);
  assign x_op   = run ? op_r    : op;
  assign x_sh   = run ? shamt_r : shamt;
  assign x_sinl = run ? sin_l_r : sin_l;
  assign x_sinr = run ? sin_r_r : sin_r;
  assign x_d    = run ? d_r     : d;
  assign exec   = run || (start ? (count != '0) : en);

  logic [N-1:0] nq, tl, tr;
  logic         nsl, nsr;
  int unsigned  s, rs;

  // Shifts by s >= N naturally clear to the fill value; rotates use s mod N.
  // Serial-out bits are taken from the value shifted by (amount-1) so no
  // variable bit index is needed.
  always_comb begin
    s   = 32'(x_sh);
    rs  = s % N;
    nq  = q;
    nsl = sout_l;
    nsr = sout_r;
    tl  = '0;
    tr  = '0;
    case (op_e'(x_op))
      OP_LOAD: nq = x_d;
      OP_CLR:  nq = '0;
      OP_SHL: begin
        nq = (q << s) | ({N{x_sinr}} & ~({N{1'b1}} << s));
        if (s != 0) begin
          tl  = q << (s - 1);
          nsl = tl[N-1];
        end
      end
      OP_SHR: begin
        nq = (q >> s) | ({N{x_sinl}} & ~({N{1'b1}} >> s));
        if (s != 0) begin
          tr  = q >> (s - 1);
          nsr = tr[0];
        end
      end
      OP_ASR: begin
        nq = (q >> s) | ({N{q[N-1]}} & ~({N{1'b1}} >> s));
        if (s != 0) begin
          tr  = q >> (s - 1);
          nsr = tr[0];
        end
      end
      OP_ROL: begin
        nq = (q << rs) | (q >> (N - rs));
        if (rs != 0) begin
          tl  = q << (rs - 1);
          nsl = tl[N-1];
        end
      end
      OP_ROR: begin
        nq = (q >> rs) | (q << (N - rs));
        if (rs != 0) begin
          tr  = q >> (rs - 1);
          nsr = tr[0];
        end
      end
      default: nq = q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      q       <= '0;
      sout_l  <= 1'b0;
      sout_r  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      op_r    <= '0;
      shamt_r <= '0;
      sin_l_r <= 1'b0;
      sin_r_r <= 1'b0;
      d_r     <= '0;
      rem     <= '0;
    end else begin
      done <= 1'b0;
      if (exec) begin
        q      <= nq;
        sout_l <= nsl;
        sout_r <= nsr;
      end
      case (state)
        S_IDLE: if (start) begin
          op_r    <= op;
          shamt_r <= shamt;
          sin_l_r <= sin_l;
          sin_r_r <= sin_r;
          d_r     <= d;
          // the launch edge already performs op #1, so a single-op burst
          // (or an empty one) completes right here
          if (count <= CW'(1)) begin
            done <= 1'b1;
          end else begin
            state <= S_RUN;
            busy  <= 1'b1;
            rem   <= count - 1'b1;
          end
        end
        S_RUN: begin
          if (rem == CW'(1)) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
          rem <= rem - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
